dom_rand_source: RTL
====================

DOM_RAND_SOURCE -- requirements
Module: dom_rand_source

Interface
REQ-001 Parameter WARMUP_CYC, default 16; number of discard cycles after seeding (4 LFSR steps each).
REQ-002 Parameter TAPS, default 32'h80200003; Galois feedback mask for x^32+x^22+x^2+x+1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 seed_valid  input  1  one-cycle strobe loading seed.
REQ-006 seed  input  32  LFSR seed value.
REQ-007 rnd_ready  input  1  consumer (DOM multiplier stage) accepts current beat.
REQ-008 rnd_valid  output  1  z0/z1 hold a fresh, unconsumed beat.
REQ-009 z0  output  2  fresh GF(2^2) mask for the multiplier z0 input.
REQ-010 z1  output  2  fresh GF(2^2) remask for the multiplier z1 input.
REQ-011 running  output  1  high in state RUN only.
REQ-012 rnd_count  output  16  number of accepted beats since last seed, saturating.

Function
REQ-013 The block SHALL implement states IDLE, WARMUP, RUN in a registered FSM.
REQ-014 The Galois step SHALL be s' = (s >> 1) ^ (s[0] ? TAPS : 0); step4(s) SHALL be four serial steps evaluated in one cycle.
REQ-015 On seed_valid in any state, the LFSR SHALL load seed (32'hACE1ACE1 if seed == 0), the warmup counter SHALL load WARMUP_CYC, the FSM SHALL enter WARMUP, and rnd_valid and rnd_count SHALL clear, all on the same edge.
REQ-016 In IDLE the LFSR SHALL hold, rnd_valid SHALL be 0, and rnd_ready SHALL be ignored.
REQ-017 In WARMUP each cycle the LFSR SHALL advance by step4 and the counter SHALL decrement; when the counter reaches 1, the FSM SHALL enter RUN on the next edge; rnd_valid SHALL stay 0.
REQ-018 In RUN the output register SHALL load when rnd_valid == 0 or (rnd_valid & rnd_ready): {z1,z0} <= step4(s)[3:0], LFSR <= step4(s), rnd_valid <= 1.
REQ-019 While rnd_valid & !rnd_ready, z0, z1 and the LFSR SHALL hold unchanged.
REQ-020 Sustained rnd_ready SHALL yield one new beat per cycle; first beat SHALL be valid exactly WARMUP_CYC+1 cycles after the seed edge.
REQ-021 No beat SHALL be presented for more than one accepted transfer (each z0/z1 pair is consumed once).
REQ-022 rnd_count SHALL increment on each rnd_valid & rnd_ready edge and saturate at 16'hFFFF.
REQ-023 seed_valid coincident with a handshake SHALL take priority: the beat counts as consumed but rnd_count clears.
REQ-024 WARMUP_CYC == 0 SHALL be treated as 1.

Reset
REQ-025 When rst is asserted, without waiting for a clock edge: FSM = IDLE, LFSR = 0, counter = 0, rnd_valid = 0, z0 = z1 = 2'b00, running = 0, rnd_count = 0.
REQ-026 Reset during WARMUP or RUN SHALL discard seed and pending beat; a new seed_valid is required before further output.
REQ-027 seed_valid sampled while rst is high SHALL be ignored.

Verification
REQ-028 Reset, no seed, rnd_ready=1 for 100 cycles -> rnd_valid=0, z0=z1=0, running=0 throughout.
REQ-029 WARMUP_CYC=1, seed=32'h00000001 -> after warmup the LFSR equals step4(1); first beat {z1,z0} equals step4(step4(1))[3:0], matching the bench reference model bit-exactly for 1000 beats.
REQ-030 seed=0 -> sequence identical to seed=32'hACE1ACE1 for 500 beats.
REQ-031 Random rnd_ready (50% duty) -> z0/z1 stable while stalled, no beat duplicated or skipped against the model, and rnd_count equals the number of handshakes.
REQ-032 Reseed in RUN mid-stall -> rnd_valid=0 on the next edge, rnd_count=0, first new beat after WARMUP_CYC+1 cycles.
REQ-033 Assert rst asynchronously between edges during RUN -> all outputs 0 immediately, then behaviour as in REQ-028.

Source files
------------

// File: rtl/dom_rand_source.sv
// Fresh-randomness source for DOM masked GF(2^2) multipliers: a 32-bit Galois LFSR
// that advances four steps per cycle, with seed/warmup control and a valid/ready beat port.
module dom_rand_source #(
  parameter int unsigned WARMUP_CYC = 16,
  parameter logic [31:0] TAPS       = 32'h80200003
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_valid,
  input  logic [31:0] seed,
  input  logic        rnd_ready,
  output logic        rnd_valid,
  output logic [1:0]  z0,
  output logic [1:0]  z1,
  output logic        running,
  output logic [15:0] rnd_count
);

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    RUN
  } state_t;

  localparam int unsigned WC_EFF     = (WARMUP_CYC == 0) ? 1 : WARMUP_CYC;
  localparam logic [31:0] WC_LOAD    = WC_EFF[31:0];
  localparam logic [31:0] SEED_ZERO  = 32'hACE1ACE1;

  state_t      state;
  logic [31:0] lfsr;
  logic [31:0] lfsr_nxt;
  logic [31:0] wcnt;

  function automatic logic [31:0] step4(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int unsigned i = 0; i < 4; i++) begin
      t = (t >> 1) ^ (t[0] ? TAPS : '0);
    end
    return t;
  endfunction

  always_comb begin
    lfsr_nxt = step4(lfsr);
  end

  // seed_valid outranks every state action, including a coincident handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= '0;
      wcnt      <= '0;
      rnd_valid <= 1'b0;
      z0        <= '0;
      z1        <= '0;
      running   <= 1'b0;
      rnd_count <= '0;
    end else if (seed_valid) begin
      state     <= WARMUP;
      lfsr      <= (seed == '0) ? SEED_ZERO : seed;
      wcnt      <= WC_LOAD;
      rnd_valid <= 1'b0;
      running   <= 1'b0;
      rnd_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          rnd_valid <= 1'b0;
          running   <= 1'b0;
        end
        WARMUP: begin
          lfsr <= lfsr_nxt;
          wcnt <= wcnt - 32'd1;
          if (wcnt <= 32'd1) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (!rnd_valid || rnd_ready) begin
            {z1, z0}  <= lfsr_nxt[3:0];
            lfsr      <= lfsr_nxt;
            rnd_valid <= 1'b1;
          end
          if (rnd_valid && rnd_ready && (rnd_count != '1)) begin
            rnd_count <= rnd_count + 16'd1;
          end
        end
        default: begin
          state     <= IDLE;
          rnd_valid <= 1'b0;
          running   <= 1'b0;
        end
      endcase
    end
  end

endmodule
